// File: rtl/axis_eth_fcs_pkg.sv
// Shared constants for the Ethernet FCS checker: CRC-32 parameters and the
// width of the delay-line fill counter.
// No logic; imported by axis_eth_fcs_check.
package axis_eth_fcs_pkg;

  // IEEE 802.3 CRC-32 generator polynomial (normal form) and register preset.
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // The FCS trailer is four bytes; the delay line holds exactly that many.
  localparam int FCS_BYTES = 4;

  // Counter spans 0..FCS_BYTES inclusive.
  localparam int                CNT_W    = $clog2(FCS_BYTES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FCS_BYTES);

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR / CRC step: advances state_in by DATA_WIDTH bits of data_in.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: data_in/state_in in, data_out (per-bit feedback) and state_out out.
// REVERSE=1 gives the bit-reflected (LSB-first) form used by Ethernet CRC-32.
// Only the GALOIS configuration is implemented; other values fail elaboration.
module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "GALOIS",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  if (LFSR_CONFIG != "GALOIS") begin : g_bad_config
    $error("lfsr: only LFSR_CONFIG=\"GALOIS\" is supported");
  end

  // The reflected form is computed as the normal MSB-first Galois register
  // run on the mirrored state, with data bits consumed LSB first; the result
  // is mirrored back on the way out.
  always_comb begin
    logic [LFSR_WIDTH-1:0] st;
    logic                  d;
    logic                  fb;
    st       = '0;
    d        = 1'b0;
    fb       = 1'b0;
    data_out = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      st[i] = REVERSE ? state_in[LFSR_WIDTH-1-i] : state_in[i];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      d  = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
      // Feed-forward mode (scrambler style) keeps data out of the feedback.
      fb = st[LFSR_WIDTH-1] ^ (LFSR_FEED_FORWARD ? 1'b0 : d);
      if (REVERSE) data_out[i]              = LFSR_FEED_FORWARD ? (d ^ st[LFSR_WIDTH-1]) : fb;
      else         data_out[DATA_WIDTH-1-i] = LFSR_FEED_FORWARD ? (d ^ st[LFSR_WIDTH-1]) : fb;
      st = {st[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      if (LFSR_FEED_FORWARD) st[0] = st[0] ^ d;
    end
    state_out = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      state_out[i] = REVERSE ? st[LFSR_WIDTH-1-i] : st[i];
    end
  end

endmodule

// File: rtl/axis_eth_fcs_check.sv
// Ethernet RX FCS checker: strips the 4-byte FCS from an 8-bit AXI stream frame,
//   recomputes CRC-32 over the payload and flags bad/upstream-errored frames on tuser.
// Latency: first payload byte 1 cycle after the 5th input byte is accepted; 1 byte/cycle.
// Backpressure: single output register; s_axis_tready = m_axis_tready | ~m_axis_tvalid.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}  input frame incl. FCS; tuser = upstream error
//   m_axis_t{data,valid,ready,last,user}  payload only; tuser = frame bad (tlast beat only)
//   error_bad_fcs            one-cycle pulse per bad-FCS or runt frame
//   stat_good_frames, stat_bad_frames  (only with AXIS_ETH_FCS_CHECK_STATS_EN defined)
//     saturating 16-bit frame counters; runts count as bad
module axis_eth_fcs_check
  import axis_eth_fcs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  error_bad_fcs
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  ,
  output logic [15:0]           stat_good_frames,
  output logic [15:0]           stat_bad_frames
`endif
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("axis_eth_fcs_check: only DATA_WIDTH=8 is supported");
  end

  // Delay line: sr[0] is the oldest byte. Bytes are only released once four
  // newer bytes sit behind them, so the FCS never reaches the output.
  logic [DATA_WIDTH-1:0] sr [FCS_BYTES];
  logic [CNT_W-1:0]      count;
  logic [31:0]           crc_state;
  logic [31:0]           crc_nxt;
  logic                  tuser_acc;
  logic [DATA_WIDTH-1:0] lfsr_data_unused;

  logic                  accept;
  logic                  streaming;
  logic [31:0]           fcs_rx;
  logic                  fcs_bad;
  logic                  frame_bad;

  // CRC advanced by the byte leaving the delay line (the one being output).
  lfsr #(
    .LFSR_WIDTH        (32),
    .LFSR_POLY         (CRC_POLY),
    .LFSR_CONFIG       ("GALOIS"),
    .LFSR_FEED_FORWARD (1'b0),
    .REVERSE           (1'b1),
    .DATA_WIDTH        (DATA_WIDTH)
  ) u_crc (
    .data_in   (sr[0]),
    .state_in  (crc_state),
    .data_out  (lfsr_data_unused),
    .state_out (crc_nxt)
  );

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign streaming     = (count == CNT_FULL);

  // On the tlast beat the four newest bytes are sr[1..3] plus the incoming
  // byte; the first FCS byte on the wire is the least significant.
  assign fcs_rx    = {s_axis_tdata, sr[3], sr[2], sr[1]};
  assign fcs_bad   = (~crc_nxt != fcs_rx);
  assign frame_bad = fcs_bad | tuser_acc | s_axis_tuser;

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      crc_state     <= CRC_INIT;
      tuser_acc     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      error_bad_fcs <= 1'b0;
      for (int i = 0; i < FCS_BYTES; i++) sr[i] <= '0;
    end else begin
      error_bad_fcs <= 1'b0;

      // Output beat consumed (or register idle): drop it unless refilled below.
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
      end

      if (accept) begin
        if (streaming) begin
          m_axis_tdata  <= sr[0];
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tuser  <= s_axis_tlast & frame_bad;
          crc_state     <= crc_nxt;
        end

        if (s_axis_tlast) begin
          // End of frame; a short frame (no payload byte left) is always bad.
          count         <= '0;
          crc_state     <= CRC_INIT;
          tuser_acc     <= 1'b0;
          error_bad_fcs <= streaming ? fcs_bad : 1'b1;
        end else begin
          for (int i = 0; i < FCS_BYTES - 1; i++) sr[i] <= sr[i+1];
          sr[FCS_BYTES-1] <= s_axis_tdata;
          if (!streaming) count <= count + 1'b1;
          tuser_acc <= tuser_acc | s_axis_tuser;
        end
      end
    end
  end

`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  // A frame is good only if it produced a tlast beat with tuser clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_frames <= 16'd0;
      stat_bad_frames  <= 16'd0;
    end else if (accept && s_axis_tlast) begin
      if (streaming && !frame_bad) begin
        if (stat_good_frames != 16'hFFFF) stat_good_frames <= stat_good_frames + 16'd1;
      end else begin
        if (stat_bad_frames != 16'hFFFF) stat_bad_frames <= stat_bad_frames + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_eth_fcs_check.sv
`timescale 1ns/1ps
module tb_axis_eth_fcs_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       error_bad_fcs;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  logic [15:0] stat_good_frames;
  logic [15:0] stat_bad_frames;
`endif

  always #5 clk = ~clk;

  axis_eth_fcs_check #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .error_bad_fcs (error_bad_fcs)
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
    ,
    .stat_good_frames (stat_good_frames),
    .stat_bad_frames  (stat_bad_frames)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sink-side ready pattern: held low, toggling, or always high.
  bit bp_en    = 1'b0;
  bit hold_rdy = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (hold_rdy)   m_axis_tready = 1'b0;
    else if (bp_en) m_axis_tready = ~m_axis_tready;
    else            m_axis_tready = 1'b1;
  end

  // Output monitor.
  logic [7:0] got_dat[$];
  bit         got_last[$];
  bit         got_user[$];
  int         got_err   = 0;
  int         rule_viol = 0;
  int         stray_usr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_axis_tready !== (m_axis_tready | ~m_axis_tvalid)) rule_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_dat.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        got_user.push_back(m_axis_tuser);
      end
      if (m_axis_tuser && !(m_axis_tvalid && m_axis_tlast)) stray_usr++;
      if (error_bad_fcs) got_err++;
    end
  end

  // Reference model: frames as byte lists, CRC from the textbook bitwise rule.
  logic [7:0] fr_dat[$];
  bit         fr_usr[$];
  logic [7:0] exp_dat[$];
  bit         exp_last[$];
  bit         exp_user[$];
  int         exp_err  = 0;
  int         exp_good = 0;
  int         exp_bad  = 0;
  int         timeouts = 0;

  logic [7:0] good_bytes [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                  8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic load_good();
    fr_dat.delete(); fr_usr.delete();
    for (int i = 0; i < 13; i++) begin fr_dat.push_back(good_bytes[i]); fr_usr.push_back(1'b0); end
  endtask

  task automatic model_add();
    int n; logic [31:0] crc, rx; bit bad, anyu;
    n = fr_dat.size();
    anyu = 1'b0;
    for (int i = 0; i < n; i++) anyu |= fr_usr[i];
    if (n <= 4) begin
      exp_err++; exp_bad++;
    end else begin
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) crc = crc_byte(crc, fr_dat[i]);
      rx  = {fr_dat[n-1], fr_dat[n-2], fr_dat[n-3], fr_dat[n-4]};
      bad = ((~crc) != rx);
      for (int i = 0; i < n - 4; i++) begin
        exp_dat.push_back(fr_dat[i]);
        exp_last.push_back(i == n - 5);
        exp_user.push_back((i == n - 5) && (bad || anyu));
      end
      if (bad) exp_err++;
      if (bad || anyu) exp_bad++; else exp_good++;
    end
  endtask

  task automatic send_frame(input bit gaps);
    int n, w; bit acc;
    n = fr_dat.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fr_dat[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = fr_usr[i];
      acc = 1'b0; w = 0;
      while (!acc && w < 200) begin
        @(negedge clk); acc = s_axis_tready;
        @(posedge clk); #1; w++;
      end
      if (!acc) timeouts++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic drain();
    bp_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    int m;
    drain();
    chk({tag, "_beats"}, 32'(got_dat.size()), 32'(exp_dat.size()));
    m = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_dat%0d", tag, i),  32'(got_dat[i]),  32'(exp_dat[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
      chk($sformatf("%s_user%0d", tag, i), 32'(got_user[i]), 32'(exp_user[i]));
    end
    chk({tag, "_err_pulses"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_timeouts"}, 32'(timeouts), 32'd0);
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
    chk({tag, "_stat_good"}, 32'(stat_good_frames), 32'(exp_good));
    chk({tag, "_stat_bad"},  32'(stat_bad_frames),  32'(exp_bad));
`endif
    got_dat.delete(); got_last.delete(); got_user.delete();
    exp_dat.delete(); exp_last.delete(); exp_user.delete();
    got_err = 0; exp_err = 0; timeouts = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int plen;
    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst_err",    32'(error_bad_fcs), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    @(posedge clk); #1;

    // Good frame "123456789" + FCS: literal expectations plus model.
    load_good(); model_add(); send_frame(1'b0);
    drain();
    for (int i = 0; i < 9; i++) begin
      if (i < got_dat.size()) chk($sformatf("good_lit%0d", i), 32'(got_dat[i]), 32'h31 + i);
    end
    compare("good");

    // Bad FCS: last byte CA.
    load_good(); fr_dat[12] = 8'hCA; model_add(); send_frame(1'b0);
    compare("badfcs");

    // Runt then clean good frame, back to back.
    fr_dat = '{8'hAA, 8'hBB, 8'hCC}; fr_usr = '{1'b0, 1'b0, 1'b0};
    model_add(); send_frame(1'b0);
    load_good(); model_add(); send_frame(1'b0);
    compare("runt");

    // Backpressure with random source gaps.
    load_good(); model_add();
    bp_en = 1'b1;
    send_frame(1'b1);
    compare("bp");

    // Upstream error on byte 3 only.
    load_good(); fr_usr[2] = 1'b1; model_add(); send_frame(1'b0);
    compare("upstream");

    // Random frames: runts, valid FCS, corrupted FCS, upstream errors, back to back.
    bp_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      logic [31:0] c;
      fr_dat.delete(); fr_usr.delete();
      if ($urandom_range(0, 4) == 0) begin
        plen = $urandom_range(1, 4);
        for (int i = 0; i < plen; i++) begin fr_dat.push_back(8'($urandom)); fr_usr.push_back(1'b0); end
      end else begin
        plen = $urandom_range(1, 20);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
          fr_dat.push_back(8'($urandom)); fr_usr.push_back(1'b0);
          c = crc_byte(c, fr_dat[i]);
        end
        c = ~c;
        if ($urandom_range(0, 2) == 0) c = c ^ (32'd1 << $urandom_range(0, 31));
        for (int i = 0; i < 4; i++) begin fr_dat.push_back(c[8*i +: 8]); fr_usr.push_back(1'b0); end
        if ($urandom_range(0, 3) == 0) fr_usr[$urandom_range(0, plen + 3)] = 1'b1;
      end
      model_add();
      send_frame(1'b1);
    end
    compare("rand");

    // Reset mid-frame with the output stalled, then a good frame.
    hold_rdy = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'($urandom); s_axis_tlast = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; hold_rdy = 1'b0;
    exp_good = 0; exp_bad = 0;
    @(negedge clk);
    chk("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    load_good(); model_add(); send_frame(1'b0);
    compare("rstmid");

    chk("tready_rule_violations", 32'(rule_viol), 32'd0);
    chk("stray_tuser", 32'(stray_usr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
